// File: rtl/trail_writer.sv
// Frame buffer write-port producer: stamps square trail marks for each live bike
// once per frame, or clears the whole buffer to background on command.
module trail_writer #(
  parameter int         TRAIL_W     = 4,
  parameter logic [3:0] BLUE_CODE   = 4'h8,
  parameter logic [3:0] RED_CODE    = 4'h4,
  parameter logic [3:0] BG_CODE     = 4'h0,
  parameter int         CLEAR_WORDS = 153600
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start_clear,
  input  logic        blue_en,
  input  logic        red_en,
  input  logic [9:0]  Blue_X_real,
  input  logic [9:0]  Blue_Y_real,
  input  logic [9:0]  Red_X_real,
  input  logic [9:0]  Red_Y_real,
  output logic        WE,
  output logic [18:0] write_address,
  output logic [15:0] Data_Out,
  output logic        busy,
  output logic        clear_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, PAINT_B, PAINT_R} state_t;

  localparam logic [3:0]  ROW_LAST   = 4'(TRAIL_W - 1);
  localparam logic [2:0]  COL_LAST   = 3'(TRAIL_W / 2 - 1);
  localparam logic [18:0] CLEAR_LAST = 19'(CLEAR_WORDS - 1);
  localparam logic [15:0] BLUE_WORD  = {4'h0, BLUE_CODE, 4'h0, BLUE_CODE};
  localparam logic [15:0] RED_WORD   = {4'h0, RED_CODE, 4'h0, RED_CODE};
  localparam logic [15:0] BG_WORD    = {4'h0, BG_CODE, 4'h0, BG_CODE};

  state_t      state, state_n;
  logic        frame_q;
  logic [9:0]  x_b, y_b, x_r, y_r;
  logic        en_b, en_r;
  logic [3:0]  row_cnt, row_n, adv_row;
  logic [2:0]  col_cnt, col_n, adv_col;
  logic        frame_edge, accept, stamp_last;
  logic        we_n, done_n;
  logic [18:0] addr_n;
  logic [15:0] data_n;
  logic [19:0] first_b_in, first_r, next_b, next_r;

  // Returns {in_bounds, word_address} for stamp word (r, c) anchored at pixel (x, y).
  function automatic logic [19:0] stamp_word(input logic [9:0] x, input logic [9:0] y,
                                             input logic [3:0] r, input logic [2:0] c);
    logic [9:0]  col;
    logic [10:0] row;
    logic [18:0] addr;
    logic        ok;
    col  = (x >> 1) + {7'b0, c};
    row  = {1'b0, y} + {7'b0, r};
    addr = ({8'b0, row} << 8) + ({8'b0, row} << 6) + {9'b0, col};
    ok   = (col < 10'd320) && (row < 11'd480);
    return {ok, addr};
  endfunction

  assign frame_edge = frame_clk & ~frame_q;
  assign busy       = (state != IDLE);
  assign stamp_last = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
  assign adv_col    = (col_cnt == COL_LAST) ? 3'd0 : col_cnt + 3'd1;
  assign adv_row    = (col_cnt == COL_LAST) ? row_cnt + 4'd1 : row_cnt;
  assign first_b_in = stamp_word(Blue_X_real, Blue_Y_real, 4'd0, 3'd0);
  assign first_r    = stamp_word(x_r, y_r, 4'd0, 3'd0);
  assign next_b     = stamp_word(x_b, y_b, adv_row, adv_col);
  assign next_r     = stamp_word(x_r, y_r, adv_row, adv_col);

  // The output registers always hold the word of the current state cycle, so the
  // next-state logic prepares the word for the cycle after the edge.
  always_comb begin
    state_n = state;
    row_n   = row_cnt;
    col_n   = col_cnt;
    we_n    = 1'b0;
    addr_n  = write_address;
    data_n  = Data_Out;
    done_n  = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start_clear) begin
          state_n = CLEAR;
          we_n    = 1'b1;
          addr_n  = 19'd0;
          data_n  = BG_WORD;
        end else if (frame_edge) begin
          accept  = 1'b1;
          state_n = PAINT_B;
          row_n   = 4'd0;
          col_n   = 3'd0;
          we_n    = blue_en & first_b_in[19];
          addr_n  = first_b_in[18:0];
          data_n  = BLUE_WORD;
        end
      end
      CLEAR: begin
        if (write_address == CLEAR_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          we_n   = 1'b1;
          addr_n = write_address + 19'd1;
          data_n = BG_WORD;
        end
      end
      PAINT_B: begin
        if (start_clear) begin
          state_n = CLEAR;
          we_n    = 1'b1;
          addr_n  = 19'd0;
          data_n  = BG_WORD;
        end else if (!en_b || stamp_last) begin
          state_n = PAINT_R;
          row_n   = 4'd0;
          col_n   = 3'd0;
          we_n    = en_r & first_r[19];
          addr_n  = first_r[18:0];
          data_n  = RED_WORD;
        end else begin
          row_n  = adv_row;
          col_n  = adv_col;
          we_n   = next_b[19];
          addr_n = next_b[18:0];
          data_n = BLUE_WORD;
        end
      end
      PAINT_R: begin
        if (start_clear) begin
          state_n = CLEAR;
          we_n    = 1'b1;
          addr_n  = 19'd0;
          data_n  = BG_WORD;
        end else if (!en_r || stamp_last) begin
          state_n = IDLE;
        end else begin
          row_n  = adv_row;
          col_n  = adv_col;
          we_n   = next_r[19];
          addr_n = next_r[18:0];
          data_n = RED_WORD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      frame_q       <= 1'b0;
      WE            <= 1'b0;
      write_address <= 19'd0;
      Data_Out      <= 16'd0;
      clear_done    <= 1'b0;
      row_cnt       <= 4'd0;
      col_cnt       <= 3'd0;
      x_b           <= 10'd0;
      y_b           <= 10'd0;
      x_r           <= 10'd0;
      y_r           <= 10'd0;
      en_b          <= 1'b0;
      en_r          <= 1'b0;
    end else begin
      state         <= state_n;
      frame_q       <= frame_clk;
      WE            <= we_n;
      write_address <= addr_n;
      Data_Out      <= data_n;
      clear_done    <= done_n;
      row_cnt       <= row_n;
      col_cnt       <= col_n;
      // Both bikes are snapshotted at acceptance so mid-frame motion cannot tear a stamp.
      if (accept) begin
        x_b  <= Blue_X_real;
        y_b  <= Blue_Y_real;
        x_r  <= Red_X_real;
        y_r  <= Red_Y_real;
        en_b <= blue_en;
        en_r <= red_en;
      end
    end
  end

endmodule

// File: tb/tb_trail_writer.sv
// Self-checking bench for trail_writer: directed and randomized frames compared
// against a pixel-level stamp model, plus clear, abort and reset scenarios.
module tb_trail_writer;

  localparam int TW = 4;
  localparam int CW = 4000;
  localparam logic [15:0] BLUE_W = 16'h0808;
  localparam logic [15:0] RED_W  = 16'h0404;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, start_clear, blue_en, red_en;
  logic [9:0]  Blue_X_real, Blue_Y_real, Red_X_real, Red_Y_real;
  logic        WE, busy, clear_done;
  logic [18:0] write_address;
  logic [15:0] Data_Out;

  int compared = 0;
  int mismatched = 0;

  int          cycle = 0;
  int          got_addr[$];
  logic [15:0] got_data[$];
  int          got_cyc[$];
  int          exp_addr[$];
  logic [15:0] exp_data[$];
  int          busy_cycles = 0;
  int          done_count = 0;
  logic        done_busy, done_prev_we;
  int          done_prev_addr;
  logic        prev_we = 1'b0;
  int          prev_addr = 0;

  trail_writer #(.TRAIL_W(TW), .CLEAR_WORDS(CW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_clear(start_clear),
    .blue_en(blue_en), .red_en(red_en),
    .Blue_X_real(Blue_X_real), .Blue_Y_real(Blue_Y_real),
    .Red_X_real(Red_X_real), .Red_Y_real(Red_Y_real),
    .WE(WE), .write_address(write_address), .Data_Out(Data_Out),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 Clk = ~Clk;

  // Write-port monitor, sampled on the falling edge away from register updates.
  always @(negedge Clk) begin
    cycle++;
    if (WE) begin
      got_addr.push_back(int'(write_address));
      got_data.push_back(Data_Out);
      got_cyc.push_back(cycle);
    end
    if (busy) busy_cycles++;
    if (clear_done) begin
      done_count++;
      done_busy      = busy;
      done_prev_we   = prev_we;
      done_prev_addr = prev_addr;
    end
    prev_we   = WE;
    prev_addr = int'(write_address);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic clearLog();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    exp_addr.delete();
    exp_data.delete();
    busy_cycles = 0;
    done_count  = 0;
  endtask

  // Reference: every in-bounds pixel-pair word of the square, row-major.
  task automatic expectStamp(input int x, input int y, input logic en, input logic [15:0] w);
    for (int r = 0; r < TW; r++) begin
      for (int c = 0; c < TW / 2; c++) begin
        int col = x / 2 + c;
        int row = y + r;
        if (en && col < 320 && row < 480) begin
          exp_addr.push_back(row * 320 + col);
          exp_data.push_back(w);
        end
      end
    end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (!busy && n < 5) begin tick(1); n++; end
    n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    checkOutput({tag, "_timeout"}, busy, 0);
  endtask

  task automatic applyStimulus(input int bx, input int by, input logic be,
                               input int rx, input int ry, input logic re);
    Blue_X_real = 10'(bx);
    Blue_Y_real = 10'(by);
    Red_X_real  = 10'(rx);
    Red_Y_real  = 10'(ry);
    blue_en     = be;
    red_en      = re;
    frame_clk   = 1'b1;
    tick(1);
    frame_clk   = 1'b0;
    waitIdle("frame", 200);
    tick(2);
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, "_count"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
  endtask

  task automatic checkClearRun(input string tag, input int first);
    int bad = 0;
    checkOutput({tag, "_count"}, got_addr.size() - first, CW);
    for (int i = first; i < got_addr.size(); i++)
      if (got_addr[i] != i - first || got_data[i] != 16'h0000) bad++;
    checkOutput({tag, "_seq_bad"}, bad, 0);
    if (got_addr.size() > first)
      checkOutput({tag, "_span"}, got_cyc[got_addr.size() - 1] - got_cyc[first], CW - 1);
    checkOutput({tag, "_done_pulses"}, done_count, 1);
    checkOutput({tag, "_done_busy"}, done_busy, 0);
    checkOutput({tag, "_done_prev_we"}, done_prev_we, 1);
    checkOutput({tag, "_done_prev_addr"}, done_prev_addr, CW - 1);
  endtask

  initial begin
    int n, s, blue_n, red_n;
    int bx, by, rx, ry;
    logic be, re;

    $display("[TB] trail_writer bench start");
    Reset = 1'b1; frame_clk = 1'b0; start_clear = 1'b0; blue_en = 1'b0; red_en = 1'b0;
    Blue_X_real = '0; Blue_Y_real = '0; Red_X_real = '0; Red_Y_real = '0;
    tick(3);
    Reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("idle_we", WE, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_addr", write_address, 0);
      checkOutput("idle_data", Data_Out, 0);
      checkOutput("idle_done", clear_done, 0);
    end

    // Full clear
    clearLog();
    start_clear = 1'b1;
    tick(1);
    start_clear = 1'b0;
    waitIdle("clear", CW + 20);
    tick(2);
    checkClearRun("clear", 0);

    // Directed frames
    clearLog();
    expectStamp(100, 50, 1'b1, BLUE_W);
    expectStamp(201, 10, 1'b1, RED_W);
    applyStimulus(100, 50, 1'b1, 201, 10, 1'b1);
    compareWrites("frame_mid");
    checkOutput("frame_mid_busy", busy_cycles, TW * TW);

    clearLog();
    expectStamp(638, 478, 1'b1, BLUE_W);
    expectStamp(5, 5, 1'b0, RED_W);
    applyStimulus(638, 478, 1'b1, 5, 5, 1'b0);
    compareWrites("frame_corner");

    // Randomized frames, every third one pushed against the right/bottom edges
    for (int k = 0; k < 10; k++) begin
      bx = $urandom_range(0, 639); by = $urandom_range(0, 479);
      rx = $urandom_range(0, 639); ry = $urandom_range(0, 479);
      if (k % 3 == 0) begin
        bx = $urandom_range(630, 639); by = $urandom_range(470, 479);
        rx = $urandom_range(630, 639); ry = $urandom_range(0, 479);
      end
      be = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 3) != 0);
      clearLog();
      expectStamp(bx, by, be, BLUE_W);
      expectStamp(rx, ry, re, RED_W);
      applyStimulus(bx, by, be, rx, ry, re);
      compareWrites($sformatf("rand%0d", k));
      if (be && re) checkOutput($sformatf("rand%0d_busy", k), busy_cycles, TW * TW);
    end

    // Clear request during blue paint, with a frame edge and a clear re-request while clearing
    clearLog();
    expectStamp(300, 200, 1'b1, BLUE_W);
    Blue_X_real = 10'd300; Blue_Y_real = 10'd200; Red_X_real = 10'd10; Red_Y_real = 10'd10;
    blue_en = 1'b1; red_en = 1'b1;
    frame_clk = 1'b1;
    tick(1);
    frame_clk = 1'b0;
    n = 0;
    while (got_addr.size() < 3 && n < 20) begin tick(1); n++; end
    checkOutput("abort_wait3", got_addr.size(), 3);
    start_clear = 1'b1;
    tick(1);
    start_clear = 1'b0;
    frame_clk = 1'b1;
    tick(50);
    start_clear = 1'b1;
    tick(1);
    start_clear = 1'b0;
    waitIdle("abort_clear", CW + 50);
    tick(2);
    blue_n = 0; red_n = 0;
    foreach (got_data[i]) begin
      if (got_data[i] == BLUE_W) blue_n++;
      if (got_data[i] == RED_W) red_n++;
    end
    checkOutput("abort_blue_writes", blue_n, 3);
    checkOutput("abort_red_writes", red_n, 0);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("abort_blue_addr%0d", i), got_addr[i], exp_addr[i]);
    checkClearRun("abort_clear", 3);
    s = got_addr.size();
    tick(10);
    checkOutput("abort_edge_dropped", got_addr.size(), s);
    checkOutput("abort_idle_busy", busy, 0);
    frame_clk = 1'b0;
    tick(2);

    // Reset in the middle of a clear
    clearLog();
    start_clear = 1'b1;
    tick(1);
    start_clear = 1'b0;
    n = 0;
    while (got_addr.size() < 1501 && n < 2000) begin tick(1); n++; end
    checkOutput("rst_reach_1500", got_addr.size(), 1501);
    Reset = 1'b1;
    tick(1);
    checkOutput("rst_we", WE, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_addr", write_address, 0);
    checkOutput("rst_data", Data_Out, 0);
    Reset = 1'b0;
    checkOutput("rst_last_addr", got_addr[got_addr.size() - 1], 1500);
    tick(20);
    checkOutput("rst_no_resume", got_addr.size(), 1501);
    checkOutput("rst_no_done", done_count, 0);
    checkOutput("rst_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
